gate_input_debouncer: RTL

- Two-channel input conditioner that sits directly upstream of the two-input gate blocks (or_gate and peers).
- Takes raw, asynchronous, bouncy switch/pin levels and delivers clean, clock-synchronous a/b levels ready to drive a gate's a and b inputs.
- Also provides one-cycle rising-edge pulses and a settled flag, so downstream logic and benches know when the gate output is meaningful.

---
 rtl/gate_input_debouncer_pkg.sv | 19 +
 rtl/debounce_channel.sv | 114 +++++++++++
 rtl/gate_input_debouncer.sv | 58 +++++
 3 files changed

// File: rtl/gate_input_debouncer_pkg.sv
// Shared definitions for the two-channel gate input debouncer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gate_input_debouncer_pkg;

  // Per-channel debounce FSM.
  // STABLE_* states mean no change is pending.
  // CHECK_* states mean a candidate level is being timed.
  typedef enum logic [1:0] {
    ST_STABLE_LOW  = 2'd0,
    ST_CHECK_HIGH  = 2'd1,
    ST_STABLE_HIGH = 2'd2,
    ST_CHECK_LOW   = 2'd3
  } deb_state_e;

  localparam int unsigned DEF_STABLE_CYCLES = 1000;
  localparam int unsigned DEF_CNT_W         = 16;

endpackage

// File: rtl/debounce_channel.sv
// Single-channel conditioner: 2-flop synchronizer, then a debounce FSM with a stability counter.
// Latency: a raw level held from edge k reaches level_o at edge k+1+STABLE_CYCLES.
// Backpressure: none; this is a free-running level path.
//
// Ports:
//   clk, rst  system clock and asynchronous active-high reset
//   raw_i     unsynchronized bouncy input
//   level_o   debounced level (registered)
//   rise_o    one-cycle pulse in the cycle level_o first reads 1
//   stable_o  high while the FSM is in a STABLE_* state (registered)
module debounce_channel
  import gate_input_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,  // must be >= 2
  parameter int unsigned CNT_W         = DEF_CNT_W           // 2**CNT_W > STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic stable_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q, s2_q;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             stable_q, stable_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      state_q  <= ST_STABLE_LOW;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      stable_q <= 1'b1;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      stable_q <= stable_d;
    end
  end

  // Entering a CHECK state loads cnt=1, because the first cycle with the new level counts.
  // Committing at cnt == STABLE_CYCLES-1 therefore requires STABLE_CYCLES consecutive cycles of s2.
  // The counter never exceeds CNT_LAST, so it cannot wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    case (state_q)
      ST_STABLE_LOW: begin
        if (s2_q) begin
          state_d = ST_CHECK_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      ST_CHECK_HIGH: begin
        if (!s2_q) begin
          state_d = ST_STABLE_LOW;   // bounce rejected; clean level untouched
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STABLE_HIGH: begin
        if (!s2_q) begin
          state_d = ST_CHECK_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      ST_CHECK_LOW: begin
        if (s2_q) begin
          state_d = ST_STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
    stable_d = (state_d == ST_STABLE_LOW) || (state_d == ST_STABLE_HIGH);
  end

  assign level_o  = level_q;
  assign rise_o   = rise_q;
  assign stable_o = stable_q;

endmodule

// File: rtl/gate_input_debouncer.sv
// Two-channel input conditioner feeding a two-input gate: clean a/b levels, rise pulses, settled flag.
// Latency: raw level held from edge k appears on a/b at edge k+1+STABLE_CYCLES.
// Backpressure: none; the outputs are free-running registered levels.
//
// Ports:
//   clk, rst      system clock and asynchronous active-high reset
//   raw_a, raw_b  unsynchronized bouncy inputs
//   a, b          debounced levels
//   a_rise/b_rise one-cycle 0->1 pulses, coincident with the new level
//   settled       high when neither channel has a pending change
module gate_input_debouncer
  import gate_input_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_a,
  input  logic raw_b,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic b_rise,
  output logic settled
);

  logic a_stable;
  logic b_stable;

  debounce_channel #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_ch_a (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (raw_a),
    .level_o  (a),
    .rise_o   (a_rise),
    .stable_o (a_stable)
  );

  debounce_channel #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_ch_b (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (raw_b),
    .level_o  (b),
    .rise_o   (b_rise),
    .stable_o (b_stable)
  );

  // Both flags are registered, so settled has no path back to raw_*.
  assign settled = a_stable & b_stable;

endmodule
